// File: rtl/io_port_bank_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_port_bank_pkg : sizing helpers shared by the I/O port bank and its FIFOs
// Revision: 1.0
// ---------------------------------------------------------------------------
package io_port_bank_pkg;

    // Channel select width; a single channel still needs one select bit.
    function automatic int ch_bits(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

    function automatic int ptr_bits(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_port_bank_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_fifo : first-word fall-through FIFO with synchronous clear
// Revision: 1.0
// ---------------------------------------------------------------------------
module io_fifo
    import io_port_bank_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_BITS = ptr_bits(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0] C_DEPTH = CNT_BITS'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [PTR_BITS-1:0] r_wr_ptr;
    logic [PTR_BITS-1:0] r_rd_ptr;
    logic [CNT_BITS-1:0] r_count;
    logic                w_push;
    logic                w_pop;

    assign full   = (r_count == C_DEPTH);
    assign empty  = (r_count == '0);
    // Fullness is judged at the edge, so a pop in the same cycle never frees room for a push.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push && !clr) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_port_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_port_bank : CHANNELS buffered input/output ports between CPU and board I/O
// Revision: 1.0
// ---------------------------------------------------------------------------
module io_port_bank
    import io_port_bank_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4,
    parameter int BLOCKING = 1
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic [CHANNELS*WIDTH-1:0]     ext_in_data,
    input  logic [CHANNELS-1:0]           ext_in_valid,
    output logic [CHANNELS-1:0]           ext_in_ready,
    output logic [CHANNELS*WIDTH-1:0]     ext_out_data,
    output logic [CHANNELS-1:0]           ext_out_valid,
    input  logic [CHANNELS-1:0]           ext_out_ready,
    input  logic [ch_bits(CHANNELS)-1:0]  cpu_channel,
    input  logic                          cpu_rd,
    output logic [WIDTH-1:0]              cpu_rd_data,
    input  logic                          cpu_wr,
    input  logic [WIDTH-1:0]              cpu_wr_data,
    output logic                          cpu_stall,
    input  logic                          err_clear,
    output logic [CHANNELS-1:0]           err_underflow,
    output logic [CHANNELS-1:0]           err_overflow
);
    logic [WIDTH-1:0]    w_in_head   [CHANNELS];
    logic [WIDTH-1:0]    r_last_read [CHANNELS];
    logic [CHANNELS-1:0] w_in_full;
    logic [CHANNELS-1:0] w_in_empty;
    logic [CHANNELS-1:0] w_out_full;
    logic [CHANNELS-1:0] w_out_empty;
    logic [CHANNELS-1:0] w_in_pop;
    logic [CHANNELS-1:0] w_out_push;
    logic [CHANNELS-1:0] w_uf_set;
    logic [CHANNELS-1:0] w_of_set;
    logic [CHANNELS-1:0] r_err_uf;
    logic [CHANNELS-1:0] r_err_of;
    logic                w_ch_ok;

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
            io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
                .clk       (clk),
                .clr       (clr),
                .push      (ext_in_valid[k]),
                .push_data (ext_in_data[k*WIDTH +: WIDTH]),
                .pop       (w_in_pop[k]),
                .head      (w_in_head[k]),
                .full      (w_in_full[k]),
                .empty     (w_in_empty[k])
            );

            io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
                .clk       (clk),
                .clr       (clr),
                .push      (w_out_push[k]),
                .push_data (cpu_wr_data),
                .pop       (ext_out_ready[k]),
                .head      (ext_out_data[k*WIDTH +: WIDTH]),
                .full      (w_out_full[k]),
                .empty     (w_out_empty[k])
            );

            always_ff @(posedge clk) begin
                if (clr) begin
                    r_last_read[k] <= '0;
                end else if (w_in_pop[k]) begin
                    r_last_read[k] <= w_in_head[k];
                end
            end
        end
    endgenerate

    assign ext_in_ready  = ~w_in_full;
    assign ext_out_valid = ~w_out_empty;
    assign w_ch_ok       = (int'(cpu_channel) < CHANNELS);

    // A stall holds the whole instruction step, so neither FIFO moves while it is asserted;
    // otherwise a re-presented read/write pair would duplicate the half that succeeded.
    always_comb begin
        w_in_pop    = '0;
        w_out_push  = '0;
        w_uf_set    = '0;
        w_of_set    = '0;
        cpu_rd_data = '0;
        cpu_stall   = 1'b0;
        if (w_ch_ok) begin
            if (cpu_rd) begin
                if (!w_in_empty[cpu_channel]) begin
                    cpu_rd_data = w_in_head[cpu_channel];
                end else if (BLOCKING == 0) begin
                    cpu_rd_data           = r_last_read[cpu_channel];
                    w_uf_set[cpu_channel] = 1'b1;
                end
            end
            if (cpu_wr && w_out_full[cpu_channel] && (BLOCKING == 0)) begin
                w_of_set[cpu_channel] = 1'b1;
            end
            cpu_stall = (BLOCKING != 0) &&
                        ((cpu_rd && w_in_empty[cpu_channel]) ||
                         (cpu_wr && w_out_full[cpu_channel]));
            if (!cpu_stall) begin
                w_in_pop[cpu_channel]   = cpu_rd && !w_in_empty[cpu_channel];
                w_out_push[cpu_channel] = cpu_wr && !w_out_full[cpu_channel];
            end
        end
    end

    // A new error in the same cycle as err_clear survives the clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_err_uf <= '0;
            r_err_of <= '0;
        end else begin
            r_err_uf <= (err_clear ? '0 : r_err_uf) | w_uf_set;
            r_err_of <= (err_clear ? '0 : r_err_of) | w_of_set;
        end
    end

    assign err_underflow = r_err_uf;
    assign err_overflow  = r_err_of;

endmodule
`default_nettype wire

// File: tb/tb_io_port_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_io_port_bank : randomized and directed bench for io_port_bank (blocking and non-blocking)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_io_port_bank;
    localparam int W  = 32;
    localparam int CH = 2;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    // blocking instance
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid, in_ready;
    logic [CH*W-1:0] out_data;
    logic [CH-1:0]   out_valid, out_ready;
    logic [0:0]      ch;
    logic            rd, wr, stall, eclr;
    logic [W-1:0]    rd_data, wr_data;
    logic [CH-1:0]   uf, of;

    // non-blocking instance
    logic [CH*W-1:0] n_in_data;
    logic [CH-1:0]   n_in_valid, n_in_ready;
    logic [CH*W-1:0] n_out_data;
    logic [CH-1:0]   n_out_valid, n_out_ready;
    logic [0:0]      n_ch;
    logic            n_rd, n_wr, n_stall, n_eclr;
    logic [W-1:0]    n_rd_data, n_wr_data;
    logic [CH-1:0]   n_uf, n_of;

    io_port_bank #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D), .BLOCKING(1)) dut (
        .clk(clk), .clr(clr),
        .ext_in_data(in_data), .ext_in_valid(in_valid), .ext_in_ready(in_ready),
        .ext_out_data(out_data), .ext_out_valid(out_valid), .ext_out_ready(out_ready),
        .cpu_channel(ch), .cpu_rd(rd), .cpu_rd_data(rd_data),
        .cpu_wr(wr), .cpu_wr_data(wr_data), .cpu_stall(stall),
        .err_clear(eclr), .err_underflow(uf), .err_overflow(of)
    );

    io_port_bank #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D), .BLOCKING(0)) dut_nb (
        .clk(clk), .clr(clr),
        .ext_in_data(n_in_data), .ext_in_valid(n_in_valid), .ext_in_ready(n_in_ready),
        .ext_out_data(n_out_data), .ext_out_valid(n_out_valid), .ext_out_ready(n_out_ready),
        .cpu_channel(n_ch), .cpu_rd(n_rd), .cpu_rd_data(n_rd_data),
        .cpu_wr(n_wr), .cpu_wr_data(n_wr_data), .cpu_stall(n_stall),
        .err_clear(n_eclr), .err_underflow(n_uf), .err_overflow(n_of)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain word queues per channel, advanced once per cycle.
    logic [W-1:0] mq_in  [CH][$];
    logic [W-1:0] mq_out [CH][$];
    // Scoreboards filled by the model, drained by the monitors.
    logic [W-1:0] sb_rd [$];
    logic [W-1:0] sb_out [CH][$];
    logic [W-1:0] nb_rd_q [$];
    logic [W-1:0] nb_out_q [$];

    always @(negedge clk) begin : m_model
        int s_in [CH];
        int s_out [CH];
        bit st;
        if (clr) begin
            for (int k = 0; k < CH; k++) begin
                mq_in[k].delete();
                mq_out[k].delete();
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                s_in[k]  = mq_in[k].size();
                s_out[k] = mq_out[k].size();
                chk($sformatf("ext_in_ready[%0d]", k), in_ready[k], s_in[k] < D);
                chk($sformatf("ext_out_valid[%0d]", k), out_valid[k], s_out[k] != 0);
                if (s_out[k] != 0)
                    chk($sformatf("ext_out_head[%0d]", k), out_data[k*W +: W], mq_out[k][0]);
            end
            st = (rd && s_in[ch] == 0) || (wr && s_out[ch] == D);
            chk("cpu_stall", stall, st);
            chk("blocking_err_bits", {uf, of}, 4'b0000);
            if (!rd) chk("rd_data_idle", rd_data, 0);
            for (int k = 0; k < CH; k++)
                if (out_ready[k] && s_out[k] != 0) sb_out[k].push_back(mq_out[k].pop_front());
            if (rd && !st) sb_rd.push_back(mq_in[ch].pop_front());
            if (wr && !st) mq_out[ch].push_back(wr_data);
            for (int k = 0; k < CH; k++)
                if (in_valid[k] && s_in[k] < D) mq_in[k].push_back(in_data[k*W +: W]);
        end
    end

    always @(negedge clk) begin : m_monitor
        #2;
        if (!clr) begin
            if (rd && !stall) begin
                if (sb_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cpu_rd_data: got %0h with no read expected", rd_data);
                end else chk("cpu_rd_data", rd_data, sb_rd.pop_front());
            end
            for (int k = 0; k < CH; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (sb_out[k].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ext_out_pop[%0d]: got %0h with no word expected", k, out_data[k*W +: W]);
                    end else chk($sformatf("ext_out_data[%0d]", k), out_data[k*W +: W], sb_out[k].pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin : m_nb_monitor
        #2;
        if (!clr) begin
            chk("nb_stall", n_stall, 1'b0);
            if (n_rd) begin
                if (nb_rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL nb_rd_data: got %0h with no read expected", n_rd_data);
                end else chk("nb_rd_data", n_rd_data, nb_rd_q.pop_front());
            end
            if (n_out_valid[0] && n_out_ready[0]) begin
                if (nb_out_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL nb_out_pop: got %0h with no word expected", n_out_data[W-1:0]);
                end else chk("nb_out_data", n_out_data[W-1:0], nb_out_q.pop_front());
            end
        end
    end

    task automatic wait_no_stall(input string nm, input int max);
        int i = 0;
        @(negedge clk);
        while (stall && i < max) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (stall) begin
            errors++;
            $display("FAIL %s: stall still 1 after %0d cycles, expected 0", nm, max);
        end
        cyc();
    endtask

    initial begin : m_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        clr = 1'b1;
        in_data = '0; in_valid = '1; out_ready = '0; ch = '0;
        rd = 1'b0; wr = 1'b0; wr_data = '0; eclr = 1'b0;
        n_in_data = '0; n_in_valid = '0; n_out_ready = '0; n_ch = '0;
        n_rd = 1'b0; n_wr = 1'b0; n_wr_data = '0; n_eclr = 1'b0;

        // reset held two cycles with valid asserted
        cyc(); cyc();
        clr = 1'b0; in_valid = '0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 2'b11);
        chk("reset_out_valid", out_valid, 2'b00);
        chk("reset_stall", stall, 1'b0);
        chk("reset_rd_data", rd_data, 0);
        cyc();

        // ordering on channel 1
        for (int i = 1; i <= 4; i++) begin
            in_valid = 2'b10;
            in_data[W +: W] = 32'(i * 'h11);
            cyc();
        end
        in_valid = '0;
        @(negedge clk);
        chk("full_in_ready1", in_ready[1], 1'b0);
        cyc();
        rd = 1'b1; ch = 1'b1;
        repeat (4) cyc();
        rd = 1'b0;
        @(negedge clk);
        chk("ready_rerise", in_ready[1], 1'b1);
        cyc();

        // blocking read on empty channel 0
        rd = 1'b1; ch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_empty_rd", stall, 1'b1);
            cyc();
        end
        in_valid = 2'b01; in_data[W-1:0] = 32'hCAFE;
        cyc();
        in_valid = '0;
        @(negedge clk);
        chk("stall_release", stall, 1'b0);
        chk("cafe_rd_data", rd_data, 32'hCAFE);
        cyc();
        rd = 1'b0;

        // output backpressure on channel 0
        out_ready = '0; wr = 1'b1; ch = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_data = 32'hA0 + 32'(i);
            cyc();
        end
        wr_data = 32'hA4;
        @(negedge clk);
        chk("stall_full_wr", stall, 1'b1);
        cyc(); cyc();
        out_ready = 2'b01;
        wait_no_stall("fifth_write", 8);
        wr = 1'b0;
        repeat (8) cyc();
        out_ready = '0;

        // wrap with simultaneous push and pop on channel 1
        in_valid = 2'b10;
        for (int i = 0; i < 2; i++) begin
            in_data[W +: W] = 32'h100 + 32'(i);
            cyc();
        end
        rd = 1'b1; wr = 1'b1; ch = 1'b1; out_ready = 2'b10;
        for (int i = 2; i < 2 + 3 * D; i++) begin
            in_data[W +: W] = 32'h100 + 32'(i);
            wr_data = 32'h200 + 32'(i);
            cyc();
        end
        in_valid = '0; wr = 1'b0;
        repeat (2) cyc();
        rd = 1'b0;
        repeat (3) cyc();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = 2'($urandom);
            in_data = {$urandom, $urandom};
            out_ready = 2'($urandom);
            rd = ($urandom_range(0, 2) == 0);
            wr = ($urandom_range(0, 2) == 0);
            ch = 1'($urandom);
            wr_data = $urandom;
            eclr = ($urandom_range(0, 7) == 0);
            cyc();
        end

        // reset with data buffered
        in_valid = 2'b11; out_ready = '0; rd = 1'b0; wr = 1'b1; eclr = 1'b0;
        repeat (3) cyc();
        wr = 1'b0; clr = 1'b1;
        cyc();
        clr = 1'b0; in_valid = '0;
        @(negedge clk);
        chk("midreset_in_ready", in_ready, 2'b11);
        chk("midreset_out_valid", out_valid, 2'b00);
        cyc();

        // non-blocking instance
        n_in_valid = 2'b01; n_in_data[W-1:0] = 32'hBEEF;
        cyc();
        n_in_valid = '0;
        n_rd = 1'b1; n_ch = 1'b0;
        nb_rd_q.push_back(32'hBEEF);
        cyc();
        nb_rd_q.push_back(32'hBEEF);
        cyc();
        n_rd = 1'b0;
        @(negedge clk);
        chk("nb_underflow", n_uf, 2'b01);
        chk("nb_no_overflow", n_of, 2'b00);
        cyc();
        n_wr = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            n_wr_data = 32'(i);
            if (i <= 4) nb_out_q.push_back(32'(i));
            cyc();
        end
        n_wr = 1'b0;
        @(negedge clk);
        chk("nb_overflow", n_of, 2'b01);
        chk("nb_out_valid", n_out_valid, 2'b01);
        cyc();
        n_eclr = 1'b1;
        cyc();
        n_eclr = 1'b0;
        @(negedge clk);
        chk("nb_clear_uf", n_uf, 2'b00);
        chk("nb_clear_of", n_of, 2'b00);
        cyc();
        n_rd = 1'b1; n_eclr = 1'b1;
        nb_rd_q.push_back(32'hBEEF);
        cyc();
        n_rd = 1'b0; n_eclr = 1'b0;
        @(negedge clk);
        chk("nb_set_wins", n_uf, 2'b01);
        cyc();
        n_out_ready = 2'b01;
        repeat (6) cyc();
        n_out_ready = '0;
        @(negedge clk);
        chk("nb_dropped_word", n_out_valid, 2'b00);

        chk("sb_rd_drained", 64'(sb_rd.size()), 0);
        chk("sb_out0_drained", 64'(sb_out[0].size()), 0);
        chk("sb_out1_drained", 64'(sb_out[1].size()), 0);
        chk("nb_rd_drained", 64'(nb_rd_q.size()), 0);
        chk("nb_out_drained", 64'(nb_out_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
